// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch stage:
//             fetch state encoding, halt/nop encodings and the MIPS
//             jump-target concatenation helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // MIPS J-type target: upper six bits of the jump's PC+1 above the
  // 26-bit word index. Addresses are word-indexed, so no <<2 here.
  function automatic logic [31:0] jump_concat(input logic [31:0] pc_plus1,
                                              input logic [25:0] index);
    return {pc_plus1[31:26], index};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Purpose  : Bundles the fetch stage's memory, decode-feedback and IF/ID
//             signals.
//  Ports    : master - fetch unit side (drives PC, IF/ID, status)
//             slave  - environment side (memory data, stall, redirects)
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_if;

  logic [31:0] program_counter;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc_plus1;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output program_counter, ifid_instruction, ifid_pc_plus1, ifid_valid,
           halted, fetch_count,
    input  instruction, stall, branch_taken, branch_pc_plus1, branch_offset,
           jump, jump_target
  );

  modport slave (
    input  program_counter, ifid_instruction, ifid_pc_plus1, ifid_valid,
           halted, fetch_count,
    output instruction, stall, branch_taken, branch_pc_plus1, branch_offset,
           jump, jump_target
  );

endinterface
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module   : next_pc_calc
//  Purpose  : Combinational next-PC selection. Computes sequential PC+1,
//             branch target and jump target, all reduced modulo MEM_DEPTH
//             so the PC never leaves the instruction memory.
//  Ports    : pc              in  32  current PC
//             branch_taken    in   1  taken conditional branch
//             branch_pc_plus1 in  32  PC+1 of the branch/jump in decode
//             branch_offset   in  16  signed word offset
//             jump            in   1  unconditional jump
//             jump_target     in  26  jump word index
//             pc_plus1        out 32  (pc+1) mod MEM_DEPTH
//             redirect        out  1  jump | branch_taken
//             next_pc         out 32  selected next PC (jump > branch > seq)
//  Revision : 1.0  initial release
// ============================================================================
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc_plus1,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc_plus1,
  output logic        redirect,
  output logic [31:0] next_pc
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  logic [31:0] branch_sum;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;

  assign pc_plus1 = (pc + 32'd1) % DEPTH;

  // Negative offsets wrap through 2^32 first; for power-of-two depths the
  // modulo then lands on the expected word below the branch.
  assign branch_sum = branch_pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
  assign branch_pc  = branch_sum % DEPTH;
  assign jump_pc    = jump_concat(branch_pc_plus1, jump_target) % DEPTH;

  assign redirect = jump | branch_taken;
  assign next_pc  = jump         ? jump_pc   :
                    branch_taken ? branch_pc : pc_plus1;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, latches the word
//             returned by instruction memory into IF/ID, handles stall,
//             branch/jump redirect with flush, halt-word detection and a
//             count of valid fetches.
//  Ports    : clk    in  1  rising-edge clock
//             reset  in  1  synchronous active-high reset
//             bus    fetch_if.master  memory address/data, decode feedback,
//                    IF/ID outputs, halted, fetch_count
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic           clk,
  input  logic           reset,
  fetch_if.master        bus
);

  fetch_pkg::fetch_state_e state, state_next;

  logic [31:0] pc, pc_next;
  logic [31:0] ifid_instr, ifid_instr_next;
  logic [31:0] ifid_pp1, ifid_pp1_next;
  logic        ifid_valid, ifid_valid_next;
  logic [31:0] count, count_next;

  logic [31:0] pc_plus1;
  logic        redirect;
  logic [31:0] next_pc;

  next_pc_calc #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_next_pc_calc (
    .pc              (pc),
    .branch_taken    (bus.branch_taken),
    .branch_pc_plus1 (bus.branch_pc_plus1),
    .branch_offset   (bus.branch_offset),
    .jump            (bus.jump),
    .jump_target     (bus.jump_target),
    .pc_plus1        (pc_plus1),
    .redirect        (redirect),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= fetch_pkg::RUN;
      pc         <= RESET_PC;
      ifid_instr <= fetch_pkg::NOP_WORD;
      ifid_pp1   <= 32'd0;
      ifid_valid <= 1'b0;
      count      <= 32'd0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_instr <= ifid_instr_next;
      ifid_pp1   <= ifid_pp1_next;
      ifid_valid <= ifid_valid_next;
      count      <= count_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ifid_instr_next = ifid_instr;
    ifid_pp1_next   = ifid_pp1;
    ifid_valid_next = ifid_valid;
    count_next      = count;

    case (state)
      fetch_pkg::RUN: begin
        if (redirect) begin
          // Redirect beats stall: the word in flight is on the wrong path.
          pc_next         = next_pc;
          ifid_instr_next = fetch_pkg::NOP_WORD;
          ifid_valid_next = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (bus.instruction == HALT_WORD) begin
          // Halt word is delivered downstream, but the PC stays put.
          ifid_instr_next = bus.instruction;
          ifid_pp1_next   = pc_plus1;
          ifid_valid_next = 1'b1;
          count_next      = count + 32'd1;
          state_next      = fetch_pkg::HALTED;
        end else begin
          ifid_instr_next = bus.instruction;
          ifid_pp1_next   = pc_plus1;
          ifid_valid_next = 1'b1;
          pc_next         = pc_plus1;
          count_next      = count + 32'd1;
        end
      end
      fetch_pkg::HALTED: begin
        // Stall is ignored here; only an older redirect can restart fetch.
        ifid_valid_next = 1'b0;
        if (redirect) begin
          pc_next         = next_pc;
          ifid_instr_next = fetch_pkg::NOP_WORD;
          state_next      = fetch_pkg::RUN;
        end
      end
      default: state_next = fetch_pkg::RUN;
    endcase
  end

  assign bus.program_counter  = pc;
  assign bus.ifid_instruction = ifid_instr;
  assign bus.ifid_pc_plus1    = ifid_pp1;
  assign bus.ifid_valid       = ifid_valid;
  assign bus.halted           = (state == fetch_pkg::HALTED);
  assign bus.fetch_count      = count;

endmodule
`default_nettype wire
